// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings: transfer types, response codes and the
// default-slave state type. HSIZE/HBURST codes live in the existing defines.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default-slave states: idle, first (wait) and second (complete) error cycle
  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahb_lite_default_slave.sv
// Default slave: answers transfers to unmapped addresses. Active transfers
// get the two-cycle AHB ERROR response; IDLE/BUSY get a zero-wait OKAY.
// err_pulse is high in the cycle an erroring transfer is accepted.
module ahb_lite_default_slave
  import ahb_lite_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP,
  output logic       err_pulse
);

  ds_state_e state_q;
  ds_state_e state_d;
  logic      accept_err;

  // Active transfer to the default slave being accepted this cycle
  assign accept_err = HREADY && sel &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  // State register; reset aborts any error response in flight
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and error-entry pulse
  always_comb begin
    state_d   = state_q;
    err_pulse = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (accept_err) begin
          state_d   = DS_ERR1;
          err_pulse = 1'b1;
        end
      end
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: begin
        if (accept_err) begin
          state_d   = DS_ERR1;
          err_pulse = 1'b1;
        end else begin
          state_d = DS_IDLE;
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // Response outputs depend on state only, so HREADY has no loop through here
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      DS_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_ERROR;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_interconnect_n.sv
// AHB-Lite single-master interconnect for NUM_SLAVES slaves. Address-phase
// decode drives HSEL; a data-phase select register steers the response mux.
// Unmapped addresses go to the default slave, whose errors are counted.
module ahb_lite_interconnect_n
  import ahb_lite_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int SEL_LSB    = 28,
  parameter int SEL_W      = 4
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [31:0]                  HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [15:0]                  ERR_COUNT
);

  if ((NUM_SLAVES < 1) || (NUM_SLAVES > (1 << SEL_W))) begin : g_bad_cfg
    $fatal(1, "ahb_lite_interconnect_n: NUM_SLAVES out of range for SEL_W");
  end

  logic [SEL_W-1:0] addr_idx;
  logic             addr_hit;
  logic [SEL_W-1:0] dsel_idx;
  logic             dsel_def;
  logic             ds_readyout;
  logic             ds_resp;
  logic             err_pulse;
  logic             haddr_unused;

  assign addr_idx     = HADDR[SEL_LSB +: SEL_W];
  assign addr_hit     = |HSEL;
  // Only the select field of HADDR steers the fabric
  assign haddr_unused = ^HADDR;

  // One-hot address-phase decode; all zeros selects the default slave
  always_comb begin
    HSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL[i] = (addr_idx == i[SEL_W-1:0]);
    end
  end

  // Data-phase select follows the decode only when a transfer is accepted
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_idx <= '0;
      dsel_def <= 1'b1;
    end else if (HREADY) begin
      dsel_idx <= addr_idx;
      dsel_def <= !addr_hit;
    end
  end

  // Zero-latency response mux from the data-phase slave
  always_comb begin
    HRDATA = '0;
    HREADY = ds_readyout;
    HRESP  = ds_resp;
    if (!dsel_def) begin
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (dsel_idx == i[SEL_W-1:0]) begin
          HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
        end
      end
    end
  end

  // Saturating count of decode errors
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                               ERR_COUNT <= '0;
    else if (err_pulse && (ERR_COUNT != 16'hFFFF)) ERR_COUNT <= ERR_COUNT + 16'd1;
  end

  ahb_lite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (!addr_hit),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (ds_readyout),
    .HRESP     (ds_resp),
    .err_pulse (err_pulse)
  );

endmodule

// File: doc/ahb_lite_interconnect_n.md
AHB_LITE_INTERCONNECT_N -- requirements
Module: ahb_lite_interconnect_n

Interface
REQ-001 The block SHALL have parameter NUM_SLAVES, default 4, giving the number of attached slaves (legal range 1..16).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the read-data width.
REQ-003 The block SHALL have parameter SEL_LSB, default 28, giving the low bit of the slave-select field.
REQ-004 The block SHALL have parameter SEL_W, default 4, giving the width of the slave-select field HADDR[SEL_LSB+SEL_W-1:SEL_LSB].
REQ-005 Port HCLK, input, 1 bit: the single clock. One clock; reset is asynchronous and active-low.
REQ-006 Port HRESETn, input, 1 bit: asynchronous active-low reset.
REQ-007 Port HADDR, input, 32 bits: master address-phase address.
REQ-008 Port HTRANS, input, 2 bits: master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 Port HSEL, output, NUM_SLAVES bits: one-hot slave select.
REQ-010 Port HRDATA_S, input, NUM_SLAVES*DATA_W bits: flattened slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
REQ-011 Port HREADYOUT_S, input, NUM_SLAVES bits: per-slave ready.
REQ-012 Port HRESP_S, input, NUM_SLAVES bits: per-slave response.
REQ-013 Port HRDATA, output, DATA_W bits: read data to the master.
REQ-014 Port HREADY, output, 1 bit: ready to the master and to all slaves.
REQ-015 Port HRESP, output, 1 bit: response to the master (0 = OKAY, 1 = ERROR).
REQ-016 Port ERR_COUNT, output, 16 bits: saturating count of decode errors.

Function
REQ-017 HSEL SHALL be combinational from HADDR: bit idx is set, where idx is the value of the select field, when idx < NUM_SLAVES; otherwise HSEL SHALL be all zeros and the default slave is addressed.
REQ-018 A data-phase select register (dsel: index plus a default flag) SHALL load the address-phase decode on each HCLK rising edge where HREADY=1, and SHALL hold its value while HREADY=0.
REQ-019 HRDATA, HREADY and HRESP SHALL be taken from the slave indexed by dsel, with zero added latency (combinational path from the slave inputs).
REQ-020 When dsel marks the default slave, HRDATA SHALL be 0.
REQ-021 The default slave SHALL implement an FSM with states DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-022 DS_IDLE -> DS_ERR1 SHALL occur when HREADY=1, the default slave is addressed and HTRANS is NONSEQ or SEQ.
REQ-023 In DS_ERR1 the outputs SHALL be HREADY=0 and HRESP=1; the FSM SHALL then go to DS_ERR2 unconditionally.
REQ-024 In DS_ERR2 the outputs SHALL be HREADY=1 and HRESP=1; the FSM SHALL then go to DS_ERR1 if another erroring transfer is being accepted, else to DS_IDLE.
REQ-025 An IDLE or BUSY transfer to the default slave SHALL receive a zero-wait OKAY response (HREADY=1, HRESP=0).
REQ-026 ERR_COUNT SHALL increment by 1 on each entry to DS_ERR1 and SHALL saturate at 16'hFFFF.
REQ-027 A slave error (HRESP_S=1) SHALL be passed through unmodified and SHALL NOT increment ERR_COUNT.
REQ-028 Back-to-back transfers to different slaves SHALL switch the mux exactly at the HREADY=1 edge; the waited-on slave's signals SHALL be held for the whole wait.
REQ-029 NUM_SLAVES > 2**SEL_W SHALL cause an elaboration-time fatal error.

Reset
REQ-030 While HRESETn=0: dsel SHALL equal default/none, the FSM SHALL be in DS_IDLE, ERR_COUNT SHALL be 0, HREADY SHALL be 1, HRESP SHALL be 0 and HRDATA SHALL be 0.
REQ-031 Reset asserted mid-error, in DS_ERR1 or DS_ERR2, SHALL abort to DS_IDLE asynchronously; no completing cycle SHALL be produced.
REQ-032 After reset release, the first accepted address phase SHALL be decoded normally on the next HCLK edge.

Structure
REQ-033 HTRANS and HRESP encodings and the default-slave FSM state typedef SHALL live in the shared package ahb_lite_pkg; HSIZE and HBURST codes SHALL remain in the existing defines.
REQ-034 The default slave SHALL be the sub-module ahb_lite_default_slave (ports HCLK, HRESETn, sel, HTRANS, HREADY, HREADYOUT, HRESP, err_pulse).
REQ-035 The decode, dsel register, mux and ERR_COUNT SHALL reside in the top module; there SHALL be no other sub-modules.

Verification
REQ-036 Scenario: NUM_SLAVES=2, write to 0x0000_0001 then read 0x1000_0002 -> HSEL=01 then 10; HRDATA equals slave1 data in the read data phase.
REQ-037 Scenario: slave1 with DELAY=1 -> HREADY low for exactly 1 cycle; the next address phase is held and dsel is unchanged until HREADY=1.
REQ-038 Scenario: NONSEQ to 0x3000_0000 with NUM_SLAVES=2 -> HSEL=00; HREADY/HRESP sequence 0/1 then 1/1; ERR_COUNT=1.
REQ-039 Scenario: two consecutive NONSEQ to an unmapped address -> responses ERR1, ERR2, ERR1, ERR2; ERR_COUNT=2.
REQ-040 Scenario: IDLE to an unmapped address -> HREADY=1, HRESP=0; ERR_COUNT unchanged.
REQ-041 Scenario: HRESETn pulsed low while in DS_ERR1 -> HREADY=1, HRESP=0 and ERR_COUNT=0 immediately, with no ERR2 cycle afterwards.
